mont_exp_ctrl: RTL

- Sequences one shared Montgomery multiplier (radix-2, R = 2^WIDTH) to compute y = m^e mod n using right-to-left binary exponentiation.
- Sits between the RSA top-level command interface and the multiplier. It owns the multiplier's start/operand ports, latches the operands, issues multiply and square operations, and returns the result in the normal (non-Montgomery) domain.

---
 rtl/mont_exp_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mont_exp_ctrl.sv
// Right-to-left binary exponentiation controller that sequences one shared radix-2 Montgomery multiplier.
// Optional macro MONT_PREP_EN: converts a raw m_i into Montgomery form internally (PREP state).

module mont_exp_ctrl #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned EXP_W = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] n_i,
    input  logic [WIDTH-1:0] m_i,
    input  logic [EXP_W-1:0] e_i,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y_o,
    output logic             ma_start,
    output logic [WIDTH-1:0] ma_a,
    output logic [WIDTH-1:0] ma_b,
    output logic [WIDTH-1:0] ma_n,
    input  logic [WIDTH-1:0] ma_v,
    input  logic             ma_finish
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_SCAN, S_ISSUE, S_WAIT, S_POST, S_FIN
    } state_e;

    typedef enum logic [1:0] {OP_MUL, OP_SQR, OP_POST} op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             s_valid_q, s_valid_d;
    logic [EXP_W-1:0] e_q, e_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             ma_start_q, ma_start_d;
    logic [WIDTH-1:0] ma_a_q, ma_a_d;
    logic [WIDTH-1:0] ma_b_q, ma_b_d;
    logic [EXP_W-1:0] e_shr;
    logic             sq_dec;

`ifdef MONT_PREP_EN
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   dbl;
    logic [WIDTH:0]   dbl_sub;

    assign dbl     = {t_q, 1'b0};
    assign dbl_sub = dbl - {1'b0, n_q};
`endif

    assign e_shr = e_q >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_MUL;
            n_q        <= '0;
            t_q        <= '0;
            s_q        <= '0;
            s_valid_q  <= 1'b0;
            e_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            y_q        <= '0;
            ma_start_q <= 1'b0;
            ma_a_q     <= '0;
            ma_b_q     <= '0;
`ifdef MONT_PREP_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            n_q        <= n_d;
            t_q        <= t_d;
            s_q        <= s_d;
            s_valid_q  <= s_valid_d;
            e_q        <= e_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            y_q        <= y_d;
            ma_start_q <= ma_start_d;
            ma_a_q     <= ma_a_d;
            ma_b_q     <= ma_b_d;
`ifdef MONT_PREP_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        n_d        = n_q;
        t_d        = t_q;
        s_d        = s_q;
        s_valid_d  = s_valid_q;
        e_d        = e_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        y_d        = y_q;
        ma_start_d = 1'b0;
        ma_a_d     = ma_a_q;
        ma_b_d     = ma_b_q;
        sq_dec     = 1'b0;
`ifdef MONT_PREP_EN
        cnt_d      = cnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d       = n_i;
                    t_d       = m_i;
                    e_d       = e_i;
                    s_d       = '0;
                    s_valid_d = 1'b0;
                    op_d      = OP_MUL;
                    busy_d    = 1'b1;
`ifdef MONT_PREP_EN
                    cnt_d     = '0;
                    state_d   = S_PREP;
`else
                    state_d   = S_SCAN;
`endif
                end
            end
`ifdef MONT_PREP_EN
            // One doubling-with-reduction per cycle: T ends as m*2^WIDTH mod N.
            S_PREP: begin
                t_d   = (dbl >= {1'b0, n_q}) ? dbl_sub[WIDTH-1:0] : dbl[WIDTH-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_SCAN;
                end
            end
`endif
            S_SCAN: begin
                if (e_q[0] && s_valid_q) begin
                    op_d       = OP_MUL;
                    ma_a_d     = s_q;
                    ma_b_d     = t_q;
                    ma_start_d = 1'b1;
                    state_d    = S_ISSUE;
                end else begin
                    if (e_q[0]) begin
                        s_d       = t_q;
                        s_valid_d = 1'b1;
                    end
                    sq_dec = 1'b1;
                end
            end
            S_POST: begin
                if (s_valid_q) begin
                    op_d       = OP_POST;
                    ma_a_d     = s_q;
                    ma_b_d     = WIDTH'(1);
                    ma_start_d = 1'b1;
                    state_d    = S_ISSUE;
                end else begin
                    y_d     = WIDTH'(1);
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ma_finish) begin
                    unique case (op_q)
                        OP_MUL: begin
                            s_d    = ma_v;
                            sq_dec = 1'b1;
                        end
                        OP_SQR: begin
                            t_d     = ma_v;
                            e_d     = e_shr;
                            state_d = S_SCAN;
                        end
                        default: begin
                            y_d     = ma_v;
                            done_d  = 1'b1;
                            state_d = S_FIN;
                        end
                    endcase
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Square only while set bits remain above the current one; otherwise finish with POST.
        if (sq_dec) begin
            if (|e_shr) begin
                op_d       = OP_SQR;
                ma_a_d     = t_q;
                ma_b_d     = t_q;
                ma_start_d = 1'b1;
                state_d    = S_ISSUE;
            end else begin
                op_d    = OP_POST;
                state_d = S_POST;
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign y_o      = y_q;
    assign ma_start = ma_start_q;
    assign ma_a     = ma_a_q;
    assign ma_b     = ma_b_q;
    assign ma_n     = n_q;

endmodule
